// File: rtl/sd_magnitude.sv
// Two-stage leaky-integrator envelope detector for a 1-bit sigma-delta stream.
// Define SD_MAGNITUDE_OUTREG_EN to register the output (one extra enabled cycle of latency).
module sd_magnitude #(
   parameter int WIDTH = 16,
   parameter int GAIN  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in,
   output logic [WIDTH-1:0] out
);

   localparam int A1W = WIDTH + GAIN + 1;
   localparam int A2W = WIDTH - 1 + GAIN;
   localparam int MW  = WIDTH - 1;
   localparam logic [MW-1:0] FULL = '1;

   logic signed [A1W-1:0] acc1;
   logic signed [A1W-1:0] acc1_nxt;
   logic signed [A1W-1:0] step_pos;
   logic signed [A1W-1:0] step;
   logic signed [A1W-1:0] est_ext;
   logic [WIDTH-1:0]      est;
   logic [WIDTH-1:0]      est_abs;
   logic [MW-1:0]         mag;
   logic [MW-1:0]         mag_nxt;
   logic [MW-1:0]         avg;
   logic [A2W-1:0]        acc2;
   logic [A2W-1:0]        acc2_nxt;

   // Stage 1: est is acc1 >>> GAIN truncated to WIDTH bits, taken straight from the bit slice.
   always_comb begin
      step_pos = {{(GAIN + 2){1'b0}}, FULL};
      step     = in ? step_pos : -step_pos;
      est      = acc1[WIDTH+GAIN-1:GAIN];
      est_ext  = {{(GAIN + 1){est[WIDTH-1]}}, est};
      acc1_nxt = acc1 - est_ext + step;
   end

   // Only the most negative estimate sets the top bit of est_abs; that case clamps to full scale.
   always_comb begin
      est_abs = est[WIDTH-1] ? (~est + {{(WIDTH - 1){1'b0}}, 1'b1}) : est;
      mag_nxt = est_abs[WIDTH-1] ? FULL : est_abs[MW-1:0];
   end

   assign avg      = acc2[A2W-1:GAIN];
   assign acc2_nxt = acc2 - {{GAIN{1'b0}}, avg} + {{GAIN{1'b0}}, mag};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc1 <= '0;
      end else if (en) begin
         acc1 <= acc1_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mag <= '0;
      end else if (en) begin
         mag <= mag_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc2 <= '0;
      end else if (en) begin
         acc2 <= acc2_nxt;
      end
   end

`ifdef SD_MAGNITUDE_OUTREG_EN
   logic [WIDTH-1:0] out_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q <= '0;
      end else if (en) begin
         out_q <= {avg, 1'b0};
      end
   end

   assign out = out_q;
`else
   assign out = {avg, 1'b0};
`endif

endmodule

// File: tb/tb_sd_magnitude.sv
// Self-checking bench for sd_magnitude: reference model feeding an expected-output queue,
// a table of pattern runs with range bounds, and hand-written latency/enable/reset sequences.
module tb_sd_magnitude;

   localparam int WIDTH = 16;
   localparam int GAIN  = 6;
   localparam int F     = 32767;

   logic             clk;
   logic             rst;
   logic             en;
   logic             sd_in;
   logic [WIDTH-1:0] out;

   int checks = 0;
   int errors = 0;

   sd_magnitude #(.WIDTH(WIDTH), .GAIN(GAIN)) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .in  (sd_in),
      .out (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Reference model state
   longint m_acc1, m_mag, m_acc2, m_outq;
   int     sbq[$];

   function automatic int exp_out();
`ifdef SD_MAGNITUDE_OUTREG_EN
      return int'(m_outq);
`else
      return int'(2 * (m_acc2 >>> GAIN));
`endif
   endfunction

   task automatic model_reset();
      m_acc1 = 0;
      m_mag  = 0;
      m_acc2 = 0;
      m_outq = 0;
   endtask

   task automatic model_step(input bit b);
      longint est, avg, n_acc1, n_mag, n_acc2;
      est    = longint'(shortint'(m_acc1 >>> GAIN));
      n_acc1 = m_acc1 - est + (b ? F : -F);
      if (est < 0) n_mag = (est == -32768) ? F : -est;
      else         n_mag = est;
      avg    = m_acc2 >>> GAIN;
      n_acc2 = m_acc2 - avg + m_mag;
      m_outq = 2 * avg;
      m_acc1 = n_acc1;
      m_mag  = n_mag;
      m_acc2 = n_acc2;
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s actual=%0d required=[%0d..%0d]", name, act, lo, hi);
      end
   endtask

   // Drive one clock: push the model's expectation, pop and compare after the edge.
   task automatic step(input string name, input bit b, input bit e, input bit cmp);
      int req;
      sd_in = b;
      en    = e;
      if (e) model_step(b);
      sbq.push_back(exp_out());
      @(posedge clk);
      #1;
      req = sbq.pop_front();
      if (cmp) chk(name, int'(out), req);
   endtask

   task automatic do_reset();
      en    = 1'b0;
      sd_in = 1'b0;
      rst   = 1'b0;
      model_reset();
      sbq.delete();
      #3;
      chk("reset_out", int'(out), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   typedef struct {
      string    name;
      bit [3:0] pat;
      int       plen;
      int       clocks;
      bit       toggle_en;
      bit       mono;
      int       lo;
      int       hi;
   } run_t;

   run_t runs[5];
   int   lat_exp[4];

   initial begin
      runs[0] = '{name: "ones",        pat: 4'b0001, plen: 1, clocks: 4096, toggle_en: 1'b0, mono: 1'b1, lo: 65000, hi: 65534};
      runs[1] = '{name: "zeros",       pat: 4'b0000, plen: 1, clocks: 4096, toggle_en: 1'b0, mono: 1'b1, lo: 65000, hi: 65534};
      runs[2] = '{name: "alternate",   pat: 4'b0001, plen: 2, clocks: 4096, toggle_en: 1'b0, mono: 1'b0, lo: 0,     hi: 2047};
      runs[3] = '{name: "density75",   pat: 4'b0111, plen: 4, clocks: 4096, toggle_en: 1'b0, mono: 1'b0, lo: 31267, hi: 34267};
      runs[4] = '{name: "ones_toggle", pat: 4'b0001, plen: 1, clocks: 8192, toggle_en: 1'b1, mono: 1'b1, lo: 65534, hi: 65534};
`ifdef SD_MAGNITUDE_OUTREG_EN
      lat_exp = '{0, 0, 0, 14};
`else
      lat_exp = '{0, 0, 14, 46};
`endif

      rst   = 1'b0;
      en    = 1'b0;
      sd_in = 1'b0;

      foreach (runs[r]) begin
         int prev;
         int mono_bad;
         int k;
         do_reset();
         prev     = 0;
         mono_bad = 0;
         k        = 0;
         for (int c = 0; c < runs[r].clocks; c++) begin
            bit e;
            e = runs[r].toggle_en ? (c % 2 == 0) : 1'b1;
            step(runs[r].name, runs[r].pat[k % runs[r].plen], e, 1'b1);
            if (e) k++;
            if (int'(out) < prev) mono_bad++;
            prev = int'(out);
         end
         chk_rng({runs[r].name, "_final"}, int'(out), runs[r].lo, runs[r].hi);
         if (runs[r].mono) chk({runs[r].name, "_mono_violations"}, mono_bad, 0);
      end

      // First-update latency from reset with constant 1s
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step("latency", 1'b1, 1'b1, 1'b0);
         chk($sformatf("latency_edge%0d", i + 1), int'(out), lat_exp[i]);
      end

      // en dropped mid-run: out must hold while in wiggles
      for (int i = 0; i < 200; i++) step("pre_freeze", 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step("freeze", 1'(i % 2), 1'b0, 1'b1);
      for (int i = 0; i < 50; i++) step("post_freeze", 1'b1, 1'b1, 1'b1);

      // Reset asserted mid-cycle with in=1 clears out at once; en=0 after release keeps it 0
      for (int i = 0; i < 300; i++) step("pre_reset", 1'b1, 1'b1, 1'b1);
      chk_rng("pre_reset_nonzero", int'(out), 1, 65534);
      #2;
      rst = 1'b0;
      model_reset();
      sbq.delete();
      #1;
      chk("async_reset_out", int'(out), 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 100; i++) step("hold_after_reset", 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step("restart", 1'b1, 1'b1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
